pc_gen: RTL
===========

// Module: pc_gen
// PURPOSE
//  Parametrised fetch-PC generator. Successor to the single-register PC: it adds multi-instruction
//  fetch groups, prioritised redirects, a valid/ready request handshake to the I-cache, a one-deep
//  redirect buffer and detection of misaligned fetch addresses. It sits at the head of the IF stage
//  and drives the address of every fetch request.
// PARAMETERS
//  PC_W      32            PC width in bits
//  RST_ADDR  32'hBFC0_0000 boot PC; equals PCRstAddr
//  FETCH_N   2             instructions per fetch group; power of 2, 1..8; instruction = 4 bytes
// PORTS
//  clk         in   1        clock
//  rst         in   1        synchronous, active-high reset
//  exc_valid   in   1        exception/eret redirect (highest priority)
//  exc_target  in   PC_W     exception target
//  br_valid    in   1        branch-mispredict redirect
//  br_target   in   PC_W     branch target
//  jmp_valid   in   1        jump redirect (lowest priority)
//  jmp_target  in   PC_W     jump target
//  stall       in   1        pipeline hold; blocks request acceptance
//  req_ready   in   1        I-cache can accept a request
//  req_valid   out  1        fetch request valid
//  req_pc      out  PC_W     fetch address; first slot = req_pc[OFS-1:2]
//  req_mask    out  FETCH_N  valid slots in group; bit i set iff i >= req_pc[OFS-1:2]
//  req_adel    out  1        req_pc is not 4-byte aligned (address-error tag)
// BEHAVIOUR
//  - OFS = log2(FETCH_N*4). STEP = FETCH_N*4. fire = req_valid & req_ready & ~stall.
//  - Reset: pc=RST_ADDR, state=S_BOOT, req_valid=0, req_adel=0, buffer empty.
//    req_mask = all ones while req_valid=0.
//  - States:
//      S_BOOT     -> S_REQ unconditionally, the cycle after rst deasserts.
//      S_REQ      req_valid=1. On fire: pc <= {pc[PC_W-1:OFS],OFS'b0} + STEP (mod 2^PC_W).
//                 If req_adel=1, fire goes to S_WAIT_EXC and pc holds.
//      S_WAIT_EXC req_valid=0. Leave only on exc_valid: pc <= exc_target, go to S_REQ.
//                 br_valid/jmp_valid are ignored here.
//  - Redirect priority: exc > br > jmp; one winner per cycle.
//  - Stability: while req_valid & ~fire, req_pc, req_mask and req_adel must not change.
//  - Redirect timing:
//      In S_REQ without fire: the winner is captured in the 1-deep buffer (target + priority).
//        A later redirect overwrites the buffer only if its priority >= buffered priority.
//      On fire with a buffered or same-cycle redirect: pc <= target of the higher-priority one
//        (same-cycle wins ties). This overrides the increment; buffer clears.
//        The fired request used the old pc.
//      In S_BOOT: a redirect writes pc directly.
//  - req_adel = req_valid & (req_pc[1:0] != 0).
//  - stall=1 and req_ready=1: no fire, no pc change; redirects still buffer.
//  - rst mid-operation: reset wins over every input; buffer and state clear in that cycle.
//  - Latency: redirect -> req_pc = target in 1 cycle if fire or no request is outstanding;
//    otherwise 1 cycle after the fire.
// STRUCTURE
//  - Shared package cpu_pkg: pc_state_t enum {S_BOOT,S_REQ,S_WAIT_EXC};
//    redir_prio_t enum {PRIO_NONE,PRIO_JMP,PRIO_BR,PRIO_EXC}; PCRstAddr constant.
//  - Sub-module pc_redirect_arb: priority select plus 1-deep buffer with the overwrite rule.
//    Outputs redir_valid, redir_target.
//  - pc_gen: PC register, FSM, group increment, mask/adel logic.
// TESTING (PC_W=32, FETCH_N=2)
//  - rst=1 for 2 cycles -> req_valid=0; 1st cycle after release req_valid=0 (S_BOOT),
//    then req_valid=1, req_pc=BFC00000, req_mask=2'b11.
//  - req_ready=1, stall=0 -> req_pc sequence BFC00000, BFC00008, BFC00010.
//    pc=FFFFFFF8 fire -> 00000000.
//  - req_ready=0 for 3 cycles; br_valid target 80001004 in cycle 2 -> req_pc held.
//    After fire: 80001004 mask 2'b10, then 80001008 mask 2'b11.
//  - Same-cycle exc 80000180 + br 80002000 -> 80000180. Buffered exc then br 80002000
//    -> exc kept. Buffered jmp then br -> br taken.
//  - jmp target 80000002 -> req_adel=1 with req_valid=1; after fire req_valid=0 and br ignored;
//    exc 80000180 -> req_pc=80000180, req_adel=0.
//  - stall=1, req_ready=1 for 4 cycles -> req_pc constant. rst asserted while buffer is full
//    -> next request is BFC00000.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU front-end types: fetch-PC FSM states, redirect priorities and the boot address.
package cpu_pkg;

    typedef enum logic [1:0] {
        S_BOOT,
        S_REQ,
        S_WAIT_EXC
    } pc_state_t;

    // Ordered so that a numerically larger value means a more important redirect.
    typedef enum logic [1:0] {
        PRIO_NONE,
        PRIO_JMP,
        PRIO_BR,
        PRIO_EXC
    } redir_prio_t;

    localparam logic [31:0] PCRstAddr = 32'hBFC0_0000;

    // True when a new redirect of priority 'incoming' may replace a held one of priority 'held'.
    function automatic logic prio_wins(input redir_prio_t incoming, input redir_prio_t held);
        return (incoming != PRIO_NONE) && (incoming >= held);
    endfunction

endpackage

// File: rtl/pc_gen_if.sv
// Fetch-request channel between the PC generator (master) and the I-cache (slave).
interface pc_gen_if #(
    parameter int PC_W    = 32,
    parameter int FETCH_N = 2
);
    logic               req_valid;
    logic               req_ready;
    logic [PC_W-1:0]    req_pc;
    logic [FETCH_N-1:0] req_mask;
    logic               req_adel;

    modport master (
        output req_valid,
        output req_pc,
        output req_mask,
        output req_adel,
        input  req_ready
    );

    modport slave (
        input  req_valid,
        input  req_pc,
        input  req_mask,
        input  req_adel,
        output req_ready
    );
endinterface

// File: rtl/pc_redirect_arb.sv
// Picks the most important redirect each cycle and holds one pending redirect until the
// outstanding fetch request is accepted.
module pc_redirect_arb
    import cpu_pkg::*;
#(
    parameter int PC_W = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            exc_valid,
    input  logic [PC_W-1:0] exc_target,
    input  logic            br_valid,
    input  logic [PC_W-1:0] br_target,
    input  logic            jmp_valid,
    input  logic [PC_W-1:0] jmp_target,
    input  logic            capture_en,
    input  logic            consume,
    output logic            redir_valid,
    output logic [PC_W-1:0] redir_target
);

    redir_prio_t     win_prio;
    logic [PC_W-1:0] win_target;
    redir_prio_t     buf_prio_q;
    logic [PC_W-1:0] buf_target_q;

    always_comb begin
        win_prio   = PRIO_NONE;
        win_target = '0;
        if (exc_valid) begin
            win_prio   = PRIO_EXC;
            win_target = exc_target;
        end else if (br_valid) begin
            win_prio   = PRIO_BR;
            win_target = br_target;
        end else if (jmp_valid) begin
            win_prio   = PRIO_JMP;
            win_target = jmp_target;
        end
    end

    // A same-cycle redirect beats the buffered one on a tie: it is the more recent decision.
    always_comb begin
        redir_valid  = 1'b0;
        redir_target = '0;
        if (prio_wins(win_prio, buf_prio_q)) begin
            redir_valid  = 1'b1;
            redir_target = win_target;
        end else if (buf_prio_q != PRIO_NONE) begin
            redir_valid  = 1'b1;
            redir_target = buf_target_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            buf_prio_q   <= PRIO_NONE;
            buf_target_q <= '0;
        end else if (consume) begin
            buf_prio_q   <= PRIO_NONE;
            buf_target_q <= '0;
        end else if (capture_en && prio_wins(win_prio, buf_prio_q)) begin
            buf_prio_q   <= win_prio;
            buf_target_q <= win_target;
        end
    end

endmodule

// File: rtl/pc_gen.sv
// Fetch-PC generator: boot sequencing, group-aligned increment, prioritised redirects and
// misaligned-address tagging for every I-cache request.
module pc_gen
    import cpu_pkg::*;
#(
    parameter int              PC_W     = 32,
    parameter logic [PC_W-1:0] RST_ADDR = PC_W'(PCRstAddr),
    parameter int              FETCH_N  = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            exc_valid,
    input  logic [PC_W-1:0] exc_target,
    input  logic            br_valid,
    input  logic [PC_W-1:0] br_target,
    input  logic            jmp_valid,
    input  logic [PC_W-1:0] jmp_target,
    input  logic            stall,
    pc_gen_if.master        req
);

    localparam int STEP = FETCH_N * 4;
    localparam int OFS  = $clog2(STEP);

    pc_state_t          state_q;
    logic [PC_W-1:0]    pc_q;
    logic               valid_q;
    logic               fire;
    logic               adel;
    logic [PC_W-1:0]    seq_pc;
    logic [FETCH_N-1:0] grp_mask;
    logic               redir_valid;
    logic [PC_W-1:0]    redir_target;

    assign fire   = valid_q & req.req_ready & ~stall;
    assign adel   = valid_q & (pc_q[1:0] != 2'b00);
    assign seq_pc = {pc_q[PC_W-1:OFS], {OFS{1'b0}}} + PC_W'(STEP);

    // Slots before the entry point of the group hold instructions we must not execute.
    always_comb begin
        grp_mask = '1;
        for (int i = 0; i < FETCH_N; i++) begin
            grp_mask[i] = (((pc_q >> 2) & PC_W'(FETCH_N - 1)) <= PC_W'(i));
        end
    end

    assign req.req_valid = valid_q;
    assign req.req_pc    = pc_q;
    assign req.req_mask  = valid_q ? grp_mask : '1;
    assign req.req_adel  = adel;

    pc_redirect_arb #(
        .PC_W(PC_W)
    ) u_arb (
        .clk         (clk),
        .rst         (rst),
        .exc_valid   (exc_valid),
        .exc_target  (exc_target),
        .br_valid    (br_valid),
        .br_target   (br_target),
        .jmp_valid   (jmp_valid),
        .jmp_target  (jmp_target),
        .capture_en  ((state_q == S_REQ) & ~fire),
        .consume     (fire),
        .redir_valid (redir_valid),
        .redir_target(redir_target)
    );

    // A misaligned request parks the front end until the exception redirect arrives.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_BOOT;
            pc_q    <= RST_ADDR;
            valid_q <= 1'b0;
        end else begin
            case (state_q)
                S_BOOT: begin
                    state_q <= S_REQ;
                    valid_q <= 1'b1;
                    if (redir_valid) begin
                        pc_q <= redir_target;
                    end
                end
                S_REQ: begin
                    if (fire) begin
                        if (adel) begin
                            state_q <= S_WAIT_EXC;
                            valid_q <= 1'b0;
                        end else if (redir_valid) begin
                            pc_q <= redir_target;
                        end else begin
                            pc_q <= seq_pc;
                        end
                    end
                end
                S_WAIT_EXC: begin
                    if (exc_valid) begin
                        pc_q    <= exc_target;
                        state_q <= S_REQ;
                        valid_q <= 1'b1;
                    end
                end
                default: begin
                    state_q <= S_BOOT;
                    valid_q <= 1'b0;
                end
            endcase
        end
    end

endmodule
